// File: rtl/cpu_io_port_pkg.sv
// Shared constants for the cpu I/O port: register offsets and default decay time.
package cpu_io_port_pkg;

  localparam int unsigned DDR_OFS  = 0;
  localparam int unsigned DATA_OFS = 1;

  // Roughly how long an undriven pin keeps its charge, in clk cycles.
  localparam int unsigned DECAY_CYCLES_DEFAULT = 350000;

endpackage

// File: rtl/cpu_io_port_if.sv
// Core-side and bus-side signals of the I/O port bus register stage.
interface cpu_io_port_if #(
  parameter int unsigned ADDR_W = 16
) ();

  logic              rdy;
  logic [ADDR_W-1:0] cpu_ab_w;
  logic [7:0]        cpu_do_w;
  logic              cpu_we_w;
  logic [7:0]        cpu_di;
  logic [ADDR_W-1:0] mem_ab;
  logic [7:0]        mem_do;
  logic              mem_we;
  logic [7:0]        mem_di;

  // Core and bus environment side.
  modport master (
    output rdy, cpu_ab_w, cpu_do_w, cpu_we_w, mem_di,
    input  cpu_di, mem_ab, mem_do, mem_we
  );

  // The port block itself.
  modport slave (
    input  rdy, cpu_ab_w, cpu_do_w, cpu_we_w, mem_di,
    output cpu_di, mem_ab, mem_do, mem_we
  );

endinterface

// File: rtl/cpu_io_port_decay.sv
// One floating-pin emulator: remembers the last driven level and drops it to 0
// after DECAY_CYCLES clocks without a driver. DECAY_CYCLES=0 holds forever.
module cpu_io_port_decay
  import cpu_io_port_pkg::*;
#(
  parameter int unsigned DECAY_W      = 20,
  parameter int unsigned DECAY_CYCLES = DECAY_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic oe,
  input  logic d,
  output logic q
);

  localparam logic [DECAY_W-1:0] LoadVal = DECAY_W'(DECAY_CYCLES);
  localparam logic [DECAY_W-1:0] LastCnt = DECAY_W'(1);

  logic [DECAY_W-1:0] cnt;
  logic               val;

  // Track the driven level while oe is high; count down once it is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      val <= 1'b0;
    end else if (oe) begin
      val <= d;
      cnt <= LoadVal;
    end else if (cnt != '0) begin
      cnt <= cnt - LastCnt;
      if (cnt == LastCnt) begin
        val <= 1'b0;
      end
    end
  end

  assign q = val;

endmodule

// File: rtl/cpu_io_port.sv
// Processor I/O port with DDR/data registers plus the core-to-bus register stage.
module cpu_io_port
  import cpu_io_port_pkg::*;
#(
  parameter int unsigned       WIDTH        = 6,
  parameter int unsigned       ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter logic [WIDTH-1:0]  DDR_RESET    = '0,
  parameter logic [WIDTH-1:0]  DATA_RESET   = '1,
  parameter int unsigned       DECAY_W      = 20,
  parameter int unsigned       DECAY_CYCLES = DECAY_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  cpu_io_port_if.slave     bus,
  output logic [WIDTH-1:0] port_out,
  output logic [WIDTH-1:0] port_oe,
  input  logic [WIDTH-1:0] port_in,
  input  logic [WIDTH-1:0] port_float
);

  localparam logic [ADDR_W-1:0] DdrAddr  = BASE_ADDR + ADDR_W'(DDR_OFS);
  localparam logic [ADDR_W-1:0] DataAddr = BASE_ADDR + ADDR_W'(DATA_OFS);

  logic [WIDTH-1:0] ddr;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] decay_val;
  logic [WIDTH-1:0] rd;

  // Bus register stage: capture the core's next-cycle request when rdy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_ab <= '0;
      bus.mem_do <= '0;
      bus.mem_we <= 1'b0;
    end else if (bus.rdy) begin
      bus.mem_ab <= bus.cpu_ab_w;
      bus.mem_do <= bus.cpu_do_w;
      bus.mem_we <= bus.cpu_we_w;
    end
  end

  // Port register writes decode the unregistered address; RAM is written too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ddr  <= DDR_RESET;
      data <= DATA_RESET;
    end else if (bus.rdy && bus.cpu_we_w) begin
      if (bus.cpu_ab_w == DdrAddr) begin
        ddr <= bus.cpu_do_w[WIDTH-1:0];
      end
      if (bus.cpu_ab_w == DataAddr) begin
        data <= bus.cpu_do_w[WIDTH-1:0];
      end
    end
  end

  // Two-flop synchroniser for the asynchronous pin levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '1;
      sync_in   <= '1;
    end else begin
      sync_meta <= port_in;
      sync_in   <= sync_meta;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_decay
    cpu_io_port_decay #(
      .DECAY_W      (DECAY_W),
      .DECAY_CYCLES (DECAY_CYCLES)
    ) u_decay (
      .clk     (clk),
      .reset_n (reset_n),
      .oe      (ddr[i]),
      .d       (data[i]),
      .q       (decay_val[i])
    );
  end

  // Per-bit read value: own output, remembered float level, or the pin.
  always_comb begin
    rd = (ddr & data) | (~ddr & port_float & decay_val) | (~ddr & ~port_float & sync_in);
  end

  // Read mux on the registered address; port reads zero-extend.
  always_comb begin
    bus.cpu_di = '0;
    if (bus.mem_ab == DdrAddr) begin
      bus.cpu_di[WIDTH-1:0] = ddr;
    end else if (bus.mem_ab == DataAddr) begin
      bus.cpu_di[WIDTH-1:0] = rd;
    end else begin
      bus.cpu_di = bus.mem_di;
    end
  end

  assign port_out = data;
  assign port_oe  = ddr;

endmodule

// File: tb/tb_cpu_io_port.sv
// Directed bench for cpu_io_port: vector table plus hand-written decay/reset sequences.
module tb_cpu_io_port;

  localparam int unsigned WIDTH  = 6;
  localparam int unsigned ADDR_W = 16;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] port_out;
  logic [WIDTH-1:0] port_oe;
  logic [WIDTH-1:0] port_in;
  logic [WIDTH-1:0] port_float;

  int checks;
  int errors;

  cpu_io_port_if #(.ADDR_W(ADDR_W)) bus ();

  cpu_io_port #(
    .WIDTH        (WIDTH),
    .ADDR_W       (ADDR_W),
    .BASE_ADDR    (16'h0000),
    .DDR_RESET    (6'h00),
    .DATA_RESET   (6'h3F),
    .DECAY_W      (20),
    .DECAY_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .port_out   (port_out),
    .port_oe    (port_oe),
    .port_in    (port_in),
    .port_float (port_float)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ab;
    logic [7:0]  dout;
    logic        we;
    logic        rdy;
    logic [7:0]  mdi;
    logic [5:0]  exp_out;
    logic [5:0]  exp_oe;
    logic [15:0] exp_ab;
    logic [7:0]  exp_do;
    logic        exp_we;
    logic [7:0]  exp_di;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] ab, input logic [7:0] dout, input logic we,
                       input logic rdy);
    bus.cpu_ab_w = ab;
    bus.cpu_do_w = dout;
    bus.cpu_we_w = we;
    bus.rdy      = rdy;
  endtask

  // After a DDR write clears bit 5, the float level 1 must read for 8 clocks.
  task automatic decay_run(input string tag, input logic idle_rdy);
    for (int c = 1; c <= 9; c++) begin
      drive(16'h0001, 8'h00, 1'b0, (c == 1) ? 1'b1 : idle_rdy);
      step();
      check($sformatf("%s c%0d", tag, c), {8'h00, bus.cpu_di},
            (c < 8) ? 16'h0025 : 16'h0005);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset_n      = 1'b0;
    port_in      = 6'h2A;
    port_float   = 6'h00;
    bus.mem_di   = 8'h00;
    drive(16'h0000, 8'h00, 1'b0, 1'b0);

    // Ab ab dout we rdy mdi | out oe mem_ab mem_do we di
    vecs[0] = '{16'h0001, 8'h00, 1'b0, 1'b1, 8'h00, 6'h3F, 6'h00, 16'h0001, 8'h00, 1'b0, 8'h3F};
    vecs[1] = '{16'h0001, 8'h00, 1'b0, 1'b1, 8'h00, 6'h3F, 6'h00, 16'h0001, 8'h00, 1'b0, 8'h2A};
    vecs[2] = '{16'h0000, 8'hFF, 1'b1, 1'b1, 8'h00, 6'h3F, 6'h3F, 16'h0000, 8'hFF, 1'b1, 8'h3F};
    vecs[3] = '{16'h0001, 8'hC5, 1'b1, 1'b1, 8'h00, 6'h05, 6'h3F, 16'h0001, 8'hC5, 1'b1, 8'h05};
    vecs[4] = '{16'h1234, 8'h00, 1'b0, 1'b1, 8'h9E, 6'h05, 6'h3F, 16'h1234, 8'h00, 1'b0, 8'h9E};
    vecs[5] = '{16'h0000, 8'h00, 1'b0, 1'b1, 8'h00, 6'h05, 6'h3F, 16'h0000, 8'h00, 1'b0, 8'h3F};
    vecs[6] = '{16'h0001, 8'h3A, 1'b1, 1'b0, 8'h00, 6'h05, 6'h3F, 16'h0000, 8'h00, 1'b0, 8'h3F};
    vecs[7] = '{16'h0001, 8'h3A, 1'b1, 1'b1, 8'h00, 6'h3A, 6'h3F, 16'h0001, 8'h3A, 1'b1, 8'h3A};

    repeat (2) step();
    check("reset port_oe", {10'h0, port_oe}, 16'h0000);
    check("reset port_out", {10'h0, port_out}, 16'h003F);
    check("reset mem_we", {15'h0, bus.mem_we}, 16'h0000);
    check("reset mem_ab", bus.mem_ab, 16'h0000);
    check("reset mem_do", {8'h0, bus.mem_do}, 16'h0000);
    check("reset cpu_di", {8'h0, bus.cpu_di}, 16'h0000);
    #2 reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].ab, vecs[i].dout, vecs[i].we, vecs[i].rdy);
      bus.mem_di = vecs[i].mdi;
      step();
      check($sformatf("v%0d port_out", i), {10'h0, port_out}, {10'h0, vecs[i].exp_out});
      check($sformatf("v%0d port_oe", i), {10'h0, port_oe}, {10'h0, vecs[i].exp_oe});
      check($sformatf("v%0d mem_ab", i), bus.mem_ab, vecs[i].exp_ab);
      check($sformatf("v%0d mem_do", i), {8'h0, bus.mem_do}, {8'h0, vecs[i].exp_do});
      check($sformatf("v%0d mem_we", i), {15'h0, bus.mem_we}, {15'h0, vecs[i].exp_we});
      check($sformatf("v%0d cpu_di", i), {8'h0, bus.cpu_di}, {8'h0, vecs[i].exp_di});
    end

    // Synchroniser latency on bit 3 with all bits inputs and driven.
    bus.mem_di = 8'h00;
    port_in = 6'h00;
    drive(16'h0000, 8'h00, 1'b1, 1'b1);
    step();
    drive(16'h0001, 8'h00, 1'b0, 1'b1);
    step();
    step();
    check("sync settle", {8'h0, bus.cpu_di}, 16'h0000);
    port_in = 6'h08;
    step();
    check("sync +1", {8'h0, bus.cpu_di}, 16'h0000);
    step();
    check("sync +2", {8'h0, bus.cpu_di}, 16'h0008);

    // Float decay on bit 5 with rdy high, then with rdy low for the count.
    port_in = 6'h00;
    drive(16'h0000, 8'hFF, 1'b1, 1'b1);
    step();
    drive(16'h0001, 8'h25, 1'b1, 1'b1);
    step();
    port_float = 6'h3F;
    drive(16'h0000, 8'h1F, 1'b1, 1'b1);
    step();
    check("decay ddr", {10'h0, port_oe}, 16'h001F);
    decay_run("decay rdy1", 1'b1);

    drive(16'h0000, 8'hFF, 1'b1, 1'b1);
    step();
    drive(16'h0000, 8'h1F, 1'b1, 1'b1);
    step();
    decay_run("decay rdy0", 1'b0);

    // Data write while bit 5 is an input must not revive its float level.
    drive(16'h0001, 8'h3A, 1'b1, 1'b1);
    step();
    check("data write no decay load", {8'h0, bus.cpu_di}, 16'h001A);

    // Foreign address passes bus data, then reset lands mid-decay.
    drive(16'h0000, 8'hFF, 1'b1, 1'b1);
    step();
    drive(16'h0000, 8'h1F, 1'b1, 1'b1);
    step();
    drive(16'h1234, 8'h00, 1'b0, 1'b1);
    bus.mem_di = 8'h9E;
    step();
    check("foreign read", {8'h0, bus.cpu_di}, 16'h009E);
    step();
    #2 reset_n = 1'b0;
    #1;
    check("midreset port_oe", {10'h0, port_oe}, 16'h0000);
    check("midreset port_out", {10'h0, port_out}, 16'h003F);
    check("midreset mem_we", {15'h0, bus.mem_we}, 16'h0000);
    check("midreset mem_ab", bus.mem_ab, 16'h0000);
    check("midreset cpu_di", {8'h0, bus.cpu_di}, 16'h0000);
    drive(16'h0000, 8'h00, 1'b0, 1'b0);
    #2 reset_n = 1'b1;
    drive(16'h0001, 8'h00, 1'b0, 1'b1);
    step();
    check("post reset decay cleared", {8'h0, bus.cpu_di}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_io_port.md
Name: cpu_io_port

Overview:
- Parametrised processor I/O port plus bus register stage that sits between the cpu core and the system bus.
- Registers the core's next-cycle address, data and write-enable, gated by rdy.
- Implements a direction register (DDR) at BASE_ADDR and a data register at BASE_ADDR+1, both WIDTH bits, and intercepts reads of both.
- Emulates floating input bits: a bit switched to input with no external driver holds its last driven value for DECAY_CYCLES, then reads 0.

Parameters:
- WIDTH, 6: port width in bits, 1..8.
- ADDR_W, 16: address bus width.
- BASE_ADDR, 16'h0000: DDR address. Data register is at BASE_ADDR+1.
- DDR_RESET, all 0: DDR reset value (all bits input).
- DATA_RESET, all 1: data register reset value.
- DECAY_W, 20: decay counter width.
- DECAY_CYCLES, 350000: clk cycles a floating bit holds its value. 0 disables decay (the value holds forever).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rdy  in  1  1 = bus stage and register writes advance.
- cpu_ab_w  in  ADDR_W  core next address.
- cpu_do_w  in  8  core write data.
- cpu_we_w  in  1  core write enable.
- cpu_di  out  8  read data to core (combinational).
- mem_ab  out  ADDR_W  registered bus address.
- mem_do  out  8  registered write data.
- mem_we  out  1  registered write enable.
- mem_di  in  8  bus read data.
- port_out  out  WIDTH  data register value.
- port_oe  out  WIDTH  DDR value (1 = bit drives).
- port_in  in  WIDTH  asynchronous pin levels.
- port_float  in  WIDTH  1 = pin not externally driven.

Behaviour:
- Reset (reset_n=0, asynchronous) clears or presets all state:
  - mem_ab=0, mem_do=0, mem_we=0.
  - ddr=DDR_RESET, data=DATA_RESET.
  - Synchroniser stages all 1.
  - Decay counters 0, decay values 0.
  - Reset is honoured mid-operation; no partial state survives.
- Bus stage: at posedge clk with rdy=1, mem_ab<=cpu_ab_w, mem_do<=cpu_do_w, mem_we<=cpu_we_w. With rdy=0 all three hold.
- Port writes are write-through: mem_we still asserts for BASE_ADDR and BASE_ADDR+1, so underlying RAM is written too.
- Register writes: at posedge clk with rdy & cpu_we_w:
  - cpu_ab_w==BASE_ADDR: ddr<=cpu_do_w[WIDTH-1:0].
  - cpu_ab_w==BASE_ADDR+1: data<=cpu_do_w[WIDTH-1:0].
  - No write when rdy=0. Upper bits of cpu_do_w are ignored.
- Read mux on the registered mem_ab:
  - BASE_ADDR: cpu_di = {zeros, ddr}.
  - BASE_ADDR+1: cpu_di = {zeros, rd}.
  - Otherwise: cpu_di = mem_di.
  - Bits 7..WIDTH are always 0 for port reads.
- Per-bit read value rd[i]:
  - ddr[i]=1: data[i].
  - ddr[i]=0 and port_float[i]=1: decay_val[i].
  - ddr[i]=0 and port_float[i]=0: sync_in[i].
- Synchroniser: 2-flop on port_in. A pin change is visible in rd 2 clk later.
- Decay, per bit, every clk independent of rdy:
  - While ddr[i]=1: decay_val[i]<=data[i], cnt[i]<=DECAY_CYCLES.
  - While ddr[i]=0 and cnt[i]!=0: cnt[i]<=cnt[i]-1; when cnt[i]==1, decay_val[i]<=0 at the same edge.
  - The decision uses pre-edge ddr. On the edge where a DDR write clears bit i, the bit still loads; it is counted from the next edge, so the old value reads for exactly DECAY_CYCLES cycles after ddr[i] goes 0.
  - Writing data while ddr[i]=0 does not change decay_val[i].
  - Re-setting ddr[i]=1 mid-count reloads the counter.
  - DECAY_CYCLES=0: counter never runs and decay_val holds.
- port_out=data, port_oe=ddr, direct from registers with no extra latency.

Decomposition:
- Package cpu_io_port_pkg:
  - Offset constants DDR_OFS=0, DATA_OFS=1.
  - Default DECAY_CYCLES constant.
- One natural sub-module: cpu_io_port_decay, the per-bit decay counter. Inputs clk, reset_n, oe, d; output q. Generated WIDTH times.

Test Plan:
1. Reset with defaults -> port_oe=6'h00, port_out=6'h3F, mem_we=0. Read of BASE_ADDR+1 with port_float=0, port_in=6'h2A (held ≥2 clk) returns 8'h2A.
2. Write 8'hFF to BASE_ADDR, then 8'hC5 to BASE_ADDR+1 -> port_oe=6'h3F and port_out=6'h05. Reads return 8'h3F and 8'h05. mem_we pulses for both writes (write-through).
3. rdy=0 during a write to BASE_ADDR+1 -> data, mem_ab and mem_we unchanged. Raise rdy -> the write lands on that edge.
4. ddr=0, port_float=0, port_in 0->1 on bit 3 -> rd[3] reads 1 exactly 2 clk later.
5. DECAY_CYCLES=8, ddr[5]=1, data[5]=1, port_float[5]=1, then write ddr[5]=0 -> rd[5]=1 for 8 clk after ddr[5] falls, then 0. Repeat with rdy=0 throughout the count -> same 8-cycle timing.
6. Address 16'h1234 read with mem_di=8'h9E -> cpu_di=8'h9E. Assert reset_n=0 mid-decay -> all outputs return to reset values immediately.
